grad_dir_interp: RTL and testbench

//  Downstream consumer of the four per-direction weighted gradient sums (17-bit grad_abs

---
 rtl/grad_dir_interp.sv | 165 ++++++++++++++++
 tb/tb_grad_dir_interp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_dir_interp.sv
// Gradient-thresholded direction selector: picks the low-gradient directions (VNG style)
// and averages their colour estimates through a 3-stage valid/ready pipeline.
module grad_dir_interp #(
    parameter int unsigned pixelBitWidth = 12,
    parameter int unsigned THR_SHIFT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [pixelBitWidth+4:0] grad_n,
    input  logic [pixelBitWidth+4:0] grad_e,
    input  logic [pixelBitWidth+4:0] grad_s,
    input  logic [pixelBitWidth+4:0] grad_w,
    input  logic [pixelBitWidth-1:0] est_n,
    input  logic [pixelBitWidth-1:0] est_e,
    input  logic [pixelBitWidth-1:0] est_s,
    input  logic [pixelBitWidth-1:0] est_w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pixelBitWidth-1:0] pix_out,
    output logic [3:0]               dir_mask
);

    localparam int unsigned PW        = pixelBitWidth;
    localparam int unsigned GW        = PW + 5;
    localparam int unsigned TW        = GW + 1;
    localparam int unsigned SW        = PW + 2;
    localparam int unsigned MW        = 2 * SW;
    localparam int unsigned DIV3_MUL  = 5461;
    localparam int unsigned DIV3_RND  = 8192;
    localparam int unsigned PIX_MAX   = (1 << PW) - 1;

    logic                   stall;
    logic                   advance;

    logic [3:0][GW-1:0]     grad_in;
    logic [3:0][PW-1:0]     est_in;
    logic [GW-1:0]          gmin_d;

    logic                   s1_valid_q;
    logic [GW-1:0]          s1_gmin_q;
    logic [3:0][GW-1:0]     s1_grad_q;
    logic [3:0][PW-1:0]     s1_est_q;

    logic [TW-1:0]          thr;
    logic [3:0]             mask_d;
    logic [SW-1:0]          sum_d;
    logic [2:0]             cnt_d;

    logic                   s2_valid_q;
    logic [3:0]             s2_mask_q;
    logic [SW-1:0]          s2_sum_q;
    logic [2:0]             s2_cnt_q;

    logic [SW-1:0]          div3;
    logic [PW-1:0]          pix_d;

    logic                   out_valid_q;
    logic [PW-1:0]          pix_q;
    logic [3:0]             dmask_q;

    // A full output stage that downstream refuses freezes the whole pipe.
    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;

    assign grad_in = {grad_w, grad_s, grad_e, grad_n};
    assign est_in  = {est_w, est_s, est_e, est_n};

    always_comb begin
        gmin_d = grad_in[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (grad_in[i] < gmin_d) begin
                gmin_d = grad_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_gmin_q  <= '0;
            s1_grad_q  <= '0;
            s1_est_q   <= '0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_gmin_q <= gmin_d;
                s1_grad_q <= grad_in;
                s1_est_q  <= est_in;
            end
        end
    end

    // Threshold is one bit wider than the gradients so gmin + gmin/2 never wraps.
    assign thr = TW'(s1_gmin_q) + TW'(s1_gmin_q >> THR_SHIFT);

    always_comb begin
        mask_d = '0;
        sum_d  = '0;
        cnt_d  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mask_d[i] = (TW'(s1_grad_q[i]) <= thr);
            if (mask_d[i]) begin
                sum_d = sum_d + SW'(s1_est_q[i]);
                cnt_d = cnt_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mask_q  <= '0;
            s2_sum_q   <= '0;
            s2_cnt_q   <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mask_q <= mask_d;
                s2_sum_q  <= sum_d;
                s2_cnt_q  <= cnt_d;
            end
        end
    end

    // Divide-by-3 via reciprocal multiply: round(2^14/3) with half-LSB rounding.
    assign div3 = SW'((MW'(s2_sum_q) * MW'(DIV3_MUL) + MW'(DIV3_RND)) >> SW);

    always_comb begin
        pix_d = '0;
        case (s2_cnt_q)
            3'd1: pix_d = PW'(s2_sum_q);
            3'd2: pix_d = PW'((s2_sum_q + SW'(1)) >> 1);
            3'd3: begin
                if (div3 > SW'(PIX_MAX)) begin
                    pix_d = PW'(PIX_MAX);
                end else begin
                    pix_d = PW'(div3);
                end
            end
            default: pix_d = PW'((s2_sum_q + SW'(2)) >> 2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            dmask_q     <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                pix_q   <= pix_d;
                dmask_q <= s2_mask_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign pix_out   = pix_q;
    assign dir_mask  = dmask_q;

endmodule

// File: tb/tb_grad_dir_interp.sv
// Self-checking bench for grad_dir_interp: directed table, stall/reset sequences and a
// randomized valid/ready stream scored against a plain-arithmetic reference model.
module tb_grad_dir_interp;

    localparam int unsigned THR_SHIFT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] grad_n = '0, grad_e = '0, grad_s = '0, grad_w = '0;
    logic [11:0] est_n = '0, est_e = '0, est_s = '0, est_w = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] pix_out;
    logic [3:0]  dir_mask;

    grad_dir_interp #(.pixelBitWidth(12), .THR_SHIFT(THR_SHIFT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .grad_n(grad_n), .grad_e(grad_e), .grad_s(grad_s), .grad_w(grad_w),
        .est_n(est_n), .est_e(est_e), .est_s(est_s), .est_w(est_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix_out(pix_out), .dir_mask(dir_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][16:0] g;
        logic [3:0][11:0] e;
        logic [3:0]       m;
        logic [11:0]      p;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned out_cnt = 0;
    logic [15:0] sb[$];
    logic [15:0] pend_exp = '0;
    bit          last_inf = 1'b0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: select directions with grad <= gmin + gmin>>THR_SHIFT, rounded mean of ests.
    function automatic logic [15:0] ref_model(input logic [3:0][16:0] g, input logic [3:0][11:0] e);
        int unsigned gmin, t, sum, cnt, pix;
        logic [3:0] m;
        gmin = g[0];
        for (int i = 1; i < 4; i++) if (g[i] < gmin) gmin = g[i];
        t = gmin + (gmin >> THR_SHIFT);
        sum = 0; cnt = 0; m = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i] <= t) begin
                m[i] = 1'b1;
                sum += e[i];
                cnt++;
            end
        end
        if (cnt == 3) begin
            pix = (sum * 5461 + 8192) / 16384;
            if (pix > 4095) pix = 4095;
        end else begin
            pix = (sum + cnt / 2) / cnt;
        end
        return {m, 12'(pix)};
    endfunction

    function automatic vec_t mk(input int unsigned gn, ge, gs, gw, en, ee, es, ew,
                                input logic [3:0] m, input int unsigned p);
        vec_t v;
        v.g[0] = 17'(gn); v.g[1] = 17'(ge); v.g[2] = 17'(gs); v.g[3] = 17'(gw);
        v.e[0] = 12'(en); v.e[1] = 12'(ee); v.e[2] = 12'(es); v.e[3] = 12'(ew);
        v.m = m;
        v.p = 12'(p);
        return v;
    endfunction

    task automatic drive(input logic [3:0][16:0] g, input logic [3:0][11:0] e);
        grad_n = g[0]; grad_e = g[1]; grad_s = g[2]; grad_w = g[3];
        est_n  = e[0]; est_e  = e[1]; est_s  = e[2]; est_w  = e[3];
    endtask

    task automatic rand_bundle(output logic [3:0][16:0] g, output logic [3:0][11:0] e);
        for (int d = 0; d < 4; d++) begin
            case ($urandom_range(0, 3))
                0:       g[d] = 17'($urandom_range(0, 20));
                1:       g[d] = 17'(131071 - $urandom_range(0, 3));
                default: g[d] = 17'($urandom);
            endcase
            e[d] = ($urandom_range(0, 3) == 0) ? 12'd4095 : 12'($urandom);
        end
    endtask

    // One clock: note the handshakes seen before the edge, then score them after it.
    task automatic cycle();
        bit inf, outf, rs;
        logic [15:0] got, exp, want;
        #1;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        rs   = rst;
        got  = {dir_mask, pix_out};
        exp  = pend_exp;
        @(posedge clk);
        #1;
        last_inf = inf && !rs;
        if (!rs) begin
            if (outf) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    want = sb.pop_front();
                    chk("dir_mask", got[15:12], want[15:12]);
                    chk("pix_out", got[11:0], want[11:0]);
                end
            end
            if (inf) sb.push_back(exp);
        end
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned k = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic wait_latency(input string nm);
        int unsigned lat = 1;
        while (!out_valid && lat < 10) begin
            cycle();
            lat++;
        end
        chk(nm, lat, 3);
    endtask

    initial begin
        vec_t vecs[10];
        logic [3:0][16:0] g;
        logic [3:0][11:0] e;
        logic [11:0] hold_p;
        logic [3:0]  hold_m;
        int unsigned cnt0;

        vecs[0] = mk(100, 200, 300, 400, 1000, 2000, 3000, 4000, 4'b0001, 1000);
        vecs[1] = mk(50, 50, 50, 50, 1, 2, 3, 4, 4'b1111, 3);
        vecs[2] = mk(0, 0, 0, 5, 4095, 4095, 4095, 0, 4'b0111, 4095);
        vecs[3] = mk(10, 14, 15, 16, 100, 101, 102, 103, 4'b0111, 101);
        vecs[4] = mk(10, 10, 100, 100, 5, 6, 777, 888, 4'b0011, 6);
        vecs[5] = mk(131071, 131071, 131071, 131071, 4095, 4095, 4095, 4095, 4'b1111, 4095);
        vecs[6] = mk(0, 7, 7, 7, 9, 500, 600, 700, 4'b0001, 9);
        vecs[7] = mk(3, 4, 9, 9, 1, 2, 50, 60, 4'b0011, 2);
        vecs[8] = mk(6, 6, 6, 100, 1, 1, 0, 3000, 4'b0111, 1);
        vecs[9] = mk(9, 9, 9, 2, 10, 20, 30, 321, 4'b1000, 321);

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_dir_mask", dir_mask, 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed table, one bundle at a time with latency check
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].g, vecs[i].e);
            pend_exp = {vecs[i].m, vecs[i].p};
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            wait_latency("table_latency");
            cycle();
        end
        drain(10);

        // Three back-to-back bundles into a blocked output
        out_ready = 1'b0;
        cnt0 = out_cnt;
        for (int j = 0; j < 3; j++) begin
            rand_bundle(g, e);
            drive(g, e);
            pend_exp = ref_model(g, e);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        hold_p = pix_out;
        hold_m = dir_mask;
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_ready", in_ready, 0);
            chk("stall_hold_pix", pix_out, hold_p);
            chk("stall_hold_mask", dir_mask, hold_m);
        end
        drain(10);
        chk("stall_out_count", out_cnt - cnt0, 3);

        // Reset with two bundles in flight
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            rand_bundle(g, e);
            g[0] = 17'd0;
            e[0] = 12'd4095;
            drive(g, e);
            pend_exp = ref_model(g, e);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pix_out", pix_out, 0);
        chk("midrst_dir_mask", dir_mask, 0);
        cnt0 = out_cnt;
        for (int j = 0; j < 4; j++) cycle();
        chk("midrst_no_stale", out_cnt - cnt0, 0);
        rand_bundle(g, e);
        drive(g, e);
        pend_exp = ref_model(g, e);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        wait_latency("postrst_latency");
        drain(10);

        // Randomized stream with random backpressure
        last_inf = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || last_inf) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rand_bundle(g, e);
                drive(g, e);
                pend_exp = ref_model(g, e);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
